// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin CPU/DMA arbiter for the single-port data RAM
module ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    state_t state, state_nxt;
    logic   owner;
    logic   last_grant;
    logic   grant_valid;
    logic   grant;

    always_comb begin
        state_nxt   = state;
        grant_valid = 1'b0;
        grant       = OWN_CPU;
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_valid = 1'b1;
                    // On a tie, the side that did not win last time gets the RAM
                    if (cpu_req && dma_req) grant = ~last_grant;
                    else                    grant = dma_req ? OWN_DMA : OWN_CPU;
                    state_nxt = ADDR;
                end
            end
            ADDR:    state_nxt = READ;
            READ:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_grant <= OWN_DMA;
        end else begin
            state <= state_nxt;
            if (grant_valid) begin
                owner      <= grant;
                last_grant <= grant;
            end
        end
    end

    // RAM inputs are captured at grant; wren is only ever high for the ADDR cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
        end else begin
            ram_wren <= grant_valid && (grant ? dma_we : cpu_we);
            if (grant_valid) begin
                ram_addr  <= grant ? dma_addr  : cpu_addr;
                ram_wdata <= grant ? dma_wdata : cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata <= '0;
            dma_rdata <= '0;
            cpu_done  <= 1'b0;
            dma_done  <= 1'b0;
        end else begin
            cpu_done <= (state == READ) && (owner == OWN_CPU);
            dma_done <= (state == READ) && (owner == OWN_DMA);
            if (state == READ) begin
                if (owner == OWN_CPU) cpu_rdata <= ram_q;
                else                  dma_rdata <= ram_q;
            end
        end
    end

    assign cpu_stall = cpu_req && !cpu_done;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_done, cpu_stall;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_done;
    logic [7:0]  dma_addr;
    logic [15:0] dma_wdata, dma_rdata;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata, ram_q;
    logic        ram_wren;

    ram_arbiter #(.AW(8), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_done(dma_done),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM megafunction: registered address/data/wren, unregistered q
    logic [15:0] mem [256];
    logic [7:0]  addr_q;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        addr_q = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        addr_q <= ram_addr;
    end
    assign ram_q = mem[addr_q];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t cpu_q[$];
    exp_t dma_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cpu(input logic [15:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        cpu_q.push_back(e);
    endtask

    task automatic push_dma(input logic [15:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        dma_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req & ~cpu_done});
        if (cpu_done && dma_done) chk("done_overlap", 32'd1, 32'd0);
        if (cpu_done) begin
            if (cpu_q.size() == 0) chk("cpu_done_unexpected", 32'd1, 32'd0);
            else begin
                e = cpu_q.pop_front();
                chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.data});
                chk("cpu_done_cycle", cyc, e.cyc);
            end
        end
        if (dma_done) begin
            if (dma_q.size() == 0) chk("dma_done_unexpected", 32'd1, 32'd0);
            else begin
                e = dma_q.pop_front();
                chk("dma_rdata", {16'd0, dma_rdata}, {16'd0, e.data});
                chk("dma_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cpu_done();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cpu_done) seen = 1;
        end
        if (!seen) chk("cpu_done_timeout", 32'd0, 32'd1);
        step();
        cpu_req = 1'b0;
    endtask

    task automatic wait_dma_done();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dma_done) seen = 1;
        end
        if (!seen) chk("dma_done_timeout", 32'd0, 32'd1);
        step();
        dma_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    int k;

    initial begin
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33; cpu_wdata = 16'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 16'h0;

        // Reset with a pending CPU request
        repeat (3) step();
        chk("rst_ram_wren",  {31'd0, ram_wren}, 32'd0);
        chk("rst_ram_addr",  {24'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        chk("rst_cpu_done",  {31'd0, cpu_done}, 32'd0);
        chk("rst_dma_done",  {31'd0, dma_done}, 32'd0);
        chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("rst_dma_rdata", {16'd0, dma_rdata}, 32'd0);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        rst = 1'b1;
        k = cyc;
        push_cpu(16'h1033, k + 3);
        step();
        chk("grant_ram_addr", {24'd0, ram_addr}, 32'h33);
        wait_cpu_done();

        // CPU write 0xBEEF to 0x12, then read it back
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h12; cpu_wdata = 16'hBEEF;
        k = cyc;
        push_cpu(16'hBEEF, k + 3);
        step();
        chk("wr_ram_wren_c1",  {31'd0, ram_wren}, 32'd1);
        chk("wr_ram_addr",     {24'd0, ram_addr}, 32'h12);
        chk("wr_ram_wdata",    {16'd0, ram_wdata}, 32'hBEEF);
        step();
        chk("wr_ram_wren_c2",  {31'd0, ram_wren}, 32'd0);
        wait_cpu_done();
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12; cpu_wdata = 16'h0;
        k = cyc;
        push_cpu(16'hBEEF, k + 3);
        step();
        chk("rd_ram_wren", {31'd0, ram_wren}, 32'd0);
        wait_cpu_done();

        // Simultaneous requests from reset, both held across several accesses
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h02;
        k = cyc;
        push_cpu(16'h1001, k + 3);
        push_dma(16'h1002, k + 7);
        push_cpu(16'h1001, k + 11);
        repeat (12) step();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        // The held DMA request is granted again after the third CPU access
        push_dma(16'h1002, k + 15);
        dma_req = 1'b1;
        wait_dma_done();

        // DMA request arriving during a CPU ADDR cycle
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h04;
        k = cyc;
        push_cpu(16'h1004, k + 3);
        step();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h07;
        push_dma(16'h1007, k + 7);
        wait_cpu_done();
        wait_dma_done();

        // CPU address changed after the grant edge is ignored
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        k = cyc;
        push_cpu(16'h1005, k + 3);
        step();
        cpu_addr = 8'h06;
        chk("late_addr_c1", {24'd0, ram_addr}, 32'h05);
        step();
        chk("late_addr_c2", {24'd0, ram_addr}, 32'h05);
        wait_cpu_done();

        // Reset during the READ cycle of a DMA read
        step();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h09;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("abort_dma_done",  {31'd0, dma_done}, 32'd0);
        chk("abort_dma_rdata", {16'd0, dma_rdata}, 32'd0);
        chk("abort_ram_wren",  {31'd0, ram_wren}, 32'd0);
        repeat (2) step();
        dma_req = 1'b0;
        rst = 1'b1;
        repeat (4) step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
        k = cyc;
        push_cpu(16'hBEEF, k + 3);
        wait_cpu_done();

        repeat (3) step();
        chk("cpu_q_drained", cpu_q.size(), 32'd0);
        chk("dma_q_drained", dma_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port data RAM between two requesters: the CPU memory stage (port `cpu`) and an auxiliary DMA/loader master (port `dma`). It arbitrates round-robin, sequences each RAM access through a fixed four-state handshake, returns read data, and drives `cpu_stall` so the pipeline holds the memory stage while its access is pending. It sits between the ExecuteMemory/MemoryWriteback registers and the RAM megafunction (registered address/data/wren inputs, unregistered q).

## Interface

Parameters:
- `AW`, 8, RAM address width in words.
- `DW`, 16, data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held high until `cpu_done`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr`  in  AW  word address.
- `cpu_wdata`  in  DW  write data.
- `cpu_rdata`  out  DW  read data; valid while `cpu_done` is high.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_stall`  out  1  `cpu_req & ~cpu_done`; combinational.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_done`: same meaning and widths as the `cpu_*` ports, for the DMA master.
- `ram_addr`  out  AW  RAM address, registered.
- `ram_wdata`  out  DW  RAM write data, registered.
- `ram_wren`  out  1  RAM write enable, registered.
- `ram_q`  in  DW  RAM read data, valid one cycle after the address is sampled.

## Operation

- FSM states: IDLE, ADDR, READ, DONE. State is registered.
- IDLE: if any request is high, grant one, register its `addr`, `wdata` and `we` into `ram_addr`, `ram_wdata` and `ram_wren`, latch the grantee in `owner`, then go to ADDR. Otherwise stay in IDLE with `ram_wren`=0.
- Arbitration: with one request, grant it. With both, grant the requester that is not `last_grant`. `last_grant` updates to `owner` on every grant. At reset it is DMA, so the CPU wins the first tie.
- ADDR: RAM inputs are stable, and the RAM samples them at the end of this cycle. A write takes effect here. Next state is READ, and `ram_wren` clears at that edge.
- READ: `ram_q` holds the addressed word. At the end of the cycle it is captured into `owner`'s `rdata` register for both reads and writes, so a write returns the written value. Next state is DONE.
- DONE: `owner`'s `done` is high for exactly this cycle, and no arbitration takes place. Next state is IDLE.
- The non-owner's `done` and `rdata` hold. `rdata` keeps its last value until the next capture.
- Requester rule: `req`, `we`, `addr` and `wdata` stay stable from assertion through the `done` cycle. A requester that holds `req` high past `done` is treated as issuing a new access, sampled in the following IDLE cycle.
- Changes to the granted requester's inputs after the grant edge are ignored, because the values are already registered.

## Timing

- Reset (`rst`=0, asynchronous) forces:
  - state = IDLE, `last_grant` = DMA
  - `ram_wren`=0, `ram_addr`=0, `ram_wdata`=0
  - `cpu_done`=0, `dma_done`=0, `cpu_rdata`=0, `dma_rdata`=0
  - `cpu_stall` then follows `cpu_req` combinationally.
- Reset asserted mid-access aborts it: no `done` is generated. A write asserted during ADDR may be lost because `ram_wren` clears immediately. Deassertion resumes in IDLE.
- Latency: with `req` high in an IDLE cycle at cycle 0, the state is ADDR at 1, READ at 2 and DONE at 3, so `done`=1 in cycle 3.
- Throughput: one access every 4 cycles. With both masters saturated, the ports alternate, each completing one access every 8 cycles.
- `cpu_stall` is high from `cpu_req` assertion through cycle 2 and low in the `cpu_done` cycle.
- A request that arrives during ADDR, READ or DONE waits for the next IDLE cycle.
- Both requests arriving in the same IDLE cycle are resolved by `last_grant`. The loser keeps waiting and is granted in the next IDLE cycle. Starvation is impossible.

## Test plan

- Reset: hold `rst`=0 with `cpu_req`=1 → all outputs at their reset values and `cpu_stall`=1. Release reset → CPU granted, `ram_addr`=`cpu_addr` in cycle 1.
- CPU write then read:
  - Write 0xBEEF to address 0x12 → `ram_wren`=1 only in cycle 1, `cpu_done` in cycle 3.
  - Then read address 0x12 → `cpu_rdata`=0xBEEF with `cpu_done`=1, 3 cycles after the request.
- Simultaneous requests from reset, both held: CPU reads 0x01, DMA reads 0x02 → grants go CPU, DMA, CPU, with `done` pulses at cycles 3, 7 and 11. `dma_done` is never high together with `cpu_done`.
- Late arrival: `dma_req` rises during a CPU ADDR cycle → DMA granted in the IDLE cycle after `cpu_done`, with `dma_done` exactly 4 cycles after the CPU's.
- Input change after grant: alter `cpu_addr` 0x05→0x06 in cycle 1 → RAM is accessed at 0x05 only.
- Reset mid-access: assert `rst`=0 during READ of a DMA read → `dma_done` is never pulsed, and the state is IDLE after release.
